pc_fetch_unit: RTL and testbench

Program-counter and instruction-register stage of the accumulator datapath. It sits directly upstream of the multicycle control FSM and supplies its `Opcode`. It executes that FSM's PC-side commands (`PCWrite`, `PCSrc`, `Branch`, `BneOrBeq`, `IRWrite`) and holds PC, IR and the ALUOut register. It also exposes decoded immediates and PC values to the ALU and memory-address muxes.

---
 rtl/accum_pkg.sv | 28 ++
 rtl/branch_resolve.sv | 27 ++
 rtl/pc_fetch_unit.sv | 85 ++++++++
 tb/tb_pc_fetch_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator datapath.
// Next-PC select encodings, IR field bounds and reset defaults.
package accum_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 11;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;
    localparam int unsigned IMM_W  = 11;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_BRANCH = 2'd2,
        PCSRC_STACK  = 2'd3
    } pcsrc_e;

    // Region-preserving jump: top PC nibble kept, word offset doubled.
    function automatic logic [15:0] jump_target(
        input logic [15:0] cur_pc,
        input logic [15:0] instr
    );
        jump_target = {cur_pc[15:12], instr[IMM_W-1:0], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// PC load enable and branch-taken decision.
// Pure combinational; registered by the fetch unit.
module branch_resolve
    import accum_pkg::*;
(
    input  logic pc_write,
    input  logic branch,
    input  logic bne_or_beq,
    input  logic alu_zero,
    output logic pc_ld,
    output logic taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        unique case (1'b1)
            bne_or_beq: cond = alu_zero;
            default:    cond = ~alu_zero;
        endcase
    end

    assign taken = branch & cond;
    assign pc_ld = pc_write | taken;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC, IR and ALUOut registers with next-PC selection.
// Feeds Opcode and immediates to control and the ALU muxes.
module pc_fetch_unit
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              IRWrite,
    input  logic [1:0]        PCWrite,
    input  logic [1:0]        Branch,
    input  logic [1:0]        BneOrBeq,
    input  logic [1:0]        PCSrc,
    output logic [OPC_W-1:0]  Opcode,
    output logic [DATA_W-1:0] imm_sext,
    output logic [DATA_W-1:0] imm_zext,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] instr_count,
    output logic              branch_taken
);

    logic              pc_ld;
    logic              taken;
    logic [DATA_W-1:0] pc_next;
    pcsrc_e            src;

    logic unused_ctrl;
    assign unused_ctrl = ^{PCWrite[1], Branch[1], BneOrBeq[1]};

    branch_resolve u_branch_resolve (
        .pc_write   (PCWrite[0]),
        .branch     (Branch[0]),
        .bne_or_beq (BneOrBeq[0]),
        .alu_zero   (alu_zero),
        .pc_ld      (pc_ld),
        .taken      (taken)
    );

    assign src = pcsrc_e'(PCSrc);

    // alu_out here is the pre-edge value, so a branch target computed
    // in Decode survives the compare that overwrites ALUOut.
    always_comb begin
        pc_next = alu_result;
        unique case (src)
            PCSRC_SEQ:    pc_next = alu_result;
            PCSRC_JUMP:   pc_next = jump_target(pc, ir);
            PCSRC_BRANCH: pc_next = alu_out;
            PCSRC_STACK:  pc_next = mem_rdata;
            default:      pc_next = alu_result;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc           <= RESET_PC;
            ir           <= '0;
            alu_out      <= '0;
            instr_count  <= '0;
            branch_taken <= 1'b0;
        end else begin
            alu_out      <= alu_result;
            branch_taken <= taken;
            if (pc_ld) begin
                pc <= pc_next;
            end
            if (IRWrite) begin
                ir          <= mem_rdata;
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign Opcode   = ir[OPC_HI:OPC_LO];
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    assign imm_sext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] mem_rdata, alu_result;
    logic        alu_zero, IRWrite;
    logic [1:0]  PCWrite, Branch, BneOrBeq, PCSrc;
    logic [4:0]  Opcode;
    logic [15:0] imm_sext, imm_zext, pc, alu_out, ir, instr_count;
    logic        branch_taken;

    int checks = 0;
    int failures = 0;

    pc_fetch_unit dut (
        .CLK(CLK), .Reset(Reset),
        .mem_rdata(mem_rdata), .alu_result(alu_result),
        .alu_zero(alu_zero), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch),
        .BneOrBeq(BneOrBeq), .PCSrc(PCSrc),
        .Opcode(Opcode), .imm_sext(imm_sext), .imm_zext(imm_zext),
        .pc(pc), .alu_out(alu_out), .ir(ir),
        .instr_count(instr_count), .branch_taken(branch_taken)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] mem;
        logic [15:0] alu;
        logic        z;
        logic        irw;
        logic        pcw;
        logic        br;
        logic        bnb;
        logic [1:0]  src;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic [15:0] e_aout;
        logic        e_bt;
        logic [15:0] e_cnt;
        logic [4:0]  e_opc;
        logic [15:0] e_sx;
        logic [15:0] e_zx;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_rdata = 16'h0; alu_result = 16'h0; alu_zero = 1'b0;
        IRWrite = 1'b0; PCWrite = 2'b00; Branch = 2'b00;
        BneOrBeq = 2'b00; PCSrc = 2'b00;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"}, pc, 16'h0000);
        chk({tag, ".ir"}, ir, 16'h0000);
        chk({tag, ".opc"}, {11'd0, Opcode}, 16'h0000);
        chk({tag, ".aout"}, alu_out, 16'h0000);
        chk({tag, ".cnt"}, instr_count, 16'h0000);
        chk({tag, ".bt"}, {15'd0, branch_taken}, 16'h0000);
    endtask

    initial begin
        //        name    mem      alu      z  irw pcw br bnb src pc       ir       aout     bt cnt      opc      sext     zext
        vecs[0]  = '{"fetch",  16'h0805, 16'h0002, 0, 1, 1, 0, 0, 2'd0, 16'h0002, 16'h0805, 16'h0002, 0, 16'd1, 5'b00001, 16'h0005, 16'h0005};
        vecs[1]  = '{"ldbne",  16'h2FFE, 16'h0010, 0, 1, 0, 0, 0, 2'd0, 16'h0002, 16'h2FFE, 16'h0010, 0, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[2]  = '{"bnetk",  16'h0000, 16'h0005, 0, 0, 0, 1, 0, 2'd2, 16'h0010, 16'h2FFE, 16'h0005, 1, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[3]  = '{"bnent",  16'h0000, 16'h0007, 1, 0, 0, 1, 0, 2'd2, 16'h0010, 16'h2FFE, 16'h0007, 0, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[4]  = '{"beqtk",  16'h0000, 16'h0000, 1, 0, 0, 1, 1, 2'd2, 16'h0007, 16'h2FFE, 16'h0000, 1, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[5]  = '{"idle",   16'h0000, 16'h0003, 0, 0, 0, 0, 0, 2'd0, 16'h0007, 16'h2FFE, 16'h0003, 0, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[6]  = '{"pcwbrf", 16'h0000, 16'h0040, 0, 0, 1, 1, 1, 2'd0, 16'h0040, 16'h2FFE, 16'h0040, 0, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[7]  = '{"setpc",  16'hA000, 16'h1111, 0, 0, 1, 0, 0, 2'd3, 16'hA000, 16'h2FFE, 16'h1111, 0, 16'd2, 5'b00101, 16'hFFFE, 16'h07FE};
        vecs[8]  = '{"ldjmp",  16'h4123, 16'h0000, 0, 1, 0, 0, 0, 2'd0, 16'hA000, 16'h4123, 16'h0000, 0, 16'd3, 5'b01000, 16'h0123, 16'h0123};
        vecs[9]  = '{"jump",   16'h0000, 16'h0000, 0, 0, 1, 0, 0, 2'd1, 16'hA246, 16'h4123, 16'h0000, 0, 16'd3, 5'b01000, 16'h0123, 16'h0123};
        vecs[10] = '{"ldneg",  16'h4400, 16'h0000, 0, 1, 0, 0, 0, 2'd0, 16'hA246, 16'h4400, 16'h0000, 0, 16'd4, 5'b01000, 16'hFC00, 16'h0400};
        vecs[11] = '{"stack",  16'h1234, 16'hBEEF, 0, 0, 1, 0, 0, 2'd3, 16'h1234, 16'h4400, 16'hBEEF, 0, 16'd4, 5'b01000, 16'hFC00, 16'h0400};
        vecs[12] = '{"pcwbrt", 16'h0000, 16'h0100, 0, 0, 1, 1, 0, 2'd0, 16'h0100, 16'h4400, 16'h0100, 1, 16'd4, 5'b01000, 16'hFC00, 16'h0400};

        // Reset held low while inputs toggle across edges.
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 16'h1357 + 16'(i); alu_result = 16'hF0F0;
            alu_zero = i[0]; IRWrite = 1'b1; PCWrite = 2'b11;
            Branch = 2'b11; BneOrBeq = 2'(i); PCSrc = 2'(i);
            @(posedge CLK); @(negedge CLK);
        end
        chk_reset("rst");
        idle_inputs();
        Reset = 1'b1;

        foreach (vecs[i]) begin
            mem_rdata = vecs[i].mem; alu_result = vecs[i].alu;
            alu_zero = vecs[i].z; IRWrite = vecs[i].irw;
            PCWrite = {1'b0, vecs[i].pcw}; Branch = {1'b0, vecs[i].br};
            BneOrBeq = {1'b0, vecs[i].bnb}; PCSrc = vecs[i].src;
            @(posedge CLK); @(negedge CLK);
            chk({vecs[i].name, ".pc"}, pc, vecs[i].e_pc);
            chk({vecs[i].name, ".ir"}, ir, vecs[i].e_ir);
            chk({vecs[i].name, ".aout"}, alu_out, vecs[i].e_aout);
            chk({vecs[i].name, ".bt"}, {15'd0, branch_taken},
                {15'd0, vecs[i].e_bt});
            chk({vecs[i].name, ".cnt"}, instr_count, vecs[i].e_cnt);
            chk({vecs[i].name, ".opc"}, {11'd0, Opcode},
                {11'd0, vecs[i].e_opc});
            chk({vecs[i].name, ".sx"}, imm_sext, vecs[i].e_sx);
            chk({vecs[i].name, ".zx"}, imm_zext, vecs[i].e_zx);
        end

        // Ignored upper control bits must not load the PC.
        idle_inputs();
        PCWrite = 2'b10; Branch = 2'b10; BneOrBeq = 2'b10;
        alu_zero = 1'b1; alu_result = 16'h7777;
        @(posedge CLK); @(negedge CLK);
        chk("hibits.pc", pc, 16'h0100);
        chk("hibits.bt", {15'd0, branch_taken}, 16'h0000);

        // Asynchronous reset mid-cycle, away from any clock edge.
        idle_inputs();
        IRWrite = 1'b1; PCWrite = 2'b01; mem_rdata = 16'h9999;
        @(posedge CLK); #2;
        Reset = 1'b0;
        #1;
        chk_reset("async");
        @(negedge CLK);
        idle_inputs();
        Reset = 1'b1;

        // First fetch after release reads at RESET_PC.
        IRWrite = 1'b1; PCWrite = 2'b01; mem_rdata = 16'h0805;
        alu_result = 16'h0002;
        @(posedge CLK); @(negedge CLK);
        chk("refetch.pc", pc, 16'h0002);
        chk("refetch.cnt", instr_count, 16'h0001);

        // Counter wrap: 65535 fetches total reach FFFF, next wraps.
        idle_inputs();
        IRWrite = 1'b1;
        for (int i = 1; i < 65535; i++) begin
            @(posedge CLK);
        end
        @(negedge CLK);
        chk("wrap.ffff", instr_count, 16'hFFFF);
        @(posedge CLK); @(negedge CLK);
        chk("wrap.zero", instr_count, 16'h0000);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
